qsfp_link_reset_ctrl: RTL and testbench
=======================================

# qsfp_link_reset_ctrl

Bring-up and recovery sequencer for the 8-lane QSFP transceiver datapath in `network`. It replaces the raw reset passthrough with a sequenced bring-up:

- pulse the shared quad PLL reset and wait for lock;
- release each lane's GT reset one lane at a time and wait for that lane's reset-done;
- retry on timeout and escalate to a sticky failure;
- recover a single dropped lane, or the whole quad on PLL lock loss.

It sits between the system reset/enable and the transceiver wrappers, and it drives the top-level `resetdone_o`.

## Interface
Parameters:
- `NUM_LANES`, 8: number of transceiver lanes sequenced.
- `RST_PULSE`, 16: cycles each reset output is held asserted per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles to wait for PLL lock before a retry.
- `DONE_TIMEOUT`, 65536: cycles to wait for a lane's reset-done before a retry.
- `MAX_RETRIES`, 3: consecutive retries allowed per step before FAIL.

Ports:
- `sys_clk_i` in 1: the single clock.
- `sys_rst_i` in 1: synchronous, active-high reset.
- `enable_i` in 1: level; low forces IDLE with all resets asserted.
- `restart_i` in 1: one-cycle pulse that restarts the full sequence and clears FAIL.
- `qpll_lock_i` in 1: PLL lock; asynchronous, synchronized internally.
- `lane_resetdone_i` in `NUM_LANES`: per-lane reset-done; asynchronous, synchronized internally.
- `qpll_reset_o` out 1: PLL reset, active-high.
- `gt_reset_o` out `NUM_LANES`: per-lane GT reset, active-high.
- `lane_up_o` out `NUM_LANES`: lane has completed bring-up.
- `resetdone_o` out 1: all lanes up (state UP).
- `fail_o` out 1: sticky failure flag.
- `retry_cnt_o` out `$clog2(MAX_RETRIES+1)`: consecutive retries on the current step.

## Operation
States are IDLE, QPLL_RST, QPLL_WAIT, LANE_RST, LANE_WAIT, UP and FAIL. `lane_idx` selects the current lane.

Transitions:
- **IDLE:** all resets asserted. If `enable_i`, go to QPLL_RST.
- **QPLL_RST:** `qpll_reset_o`=1 and all `gt_reset_o`=1 for `RST_PULSE` cycles, then go to QPLL_WAIT.
- **QPLL_WAIT:** `qpll_reset_o`=0.
  - Synced lock=1: clear the retry count, set `lane_idx` to the lowest lane with `lane_up_o`=0, go to LANE_RST.
  - `LOCK_TIMEOUT` cycles elapse: retry (see below) by going back to QPLL_RST.
- **LANE_RST:** `gt_reset_o[lane_idx]`=1 for `RST_PULSE` cycles, then go to LANE_WAIT. Lanes that are already up keep their reset low.
- **LANE_WAIT:** `gt_reset_o[lane_idx]`=0.
  - Synced `resetdone[lane_idx]`=1: set `lane_up_o[lane_idx]`, clear the retry count, go to the next lowest lane with `lane_up_o`=0. If there is none, go to UP.
  - `DONE_TIMEOUT` elapses: retry by going back to LANE_RST for the same lane.
- **Retry rule:** on a timeout, if `retry_cnt` < `MAX_RETRIES`, increment it and retry. Otherwise go to FAIL. An escalated step therefore gets `MAX_RETRIES`+1 attempts in total.
- **FAIL:** all resets asserted, `lane_up_o`=0, `fail_o`=1. Leave only via `restart_i`, `sys_rst_i` or `enable_i` low.
- **UP:** `resetdone_o`=1.
  - Synced lock drops: clear all `lane_up_o`, go to QPLL_RST.
  - Otherwise, the lowest lane whose synced resetdone dropped: clear its `lane_up_o`, go to LANE_RST for that lane. Its recovery returns to UP.

Priority within a cycle, highest first:
1. `sys_rst_i`
2. `!enable_i` → IDLE, `lane_up_o` cleared, `fail_o` cleared, retries cleared
3. `restart_i` → QPLL_RST, `lane_up_o`, `fail_o` and retries cleared
4. lock loss while in LANE_RST, LANE_WAIT or UP → QPLL_RST, `lane_up_o` cleared; not counted as a retry
5. lane drop in UP

Reset: state IDLE, `qpll_reset_o`=1, `gt_reset_o`=all ones, `lane_up_o`=0, `resetdone_o`=0, `fail_o`=0, `retry_cnt_o`=0, cycle counter 0.

## Timing
- All outputs are registered and change one cycle after the decision.
- Lock and reset-done inputs pass through 2-flop synchronizers, giving 2 cycles of input latency.
- The cycle counter is sized by `$clog2` of the largest of `RST_PULSE`, `LOCK_TIMEOUT` and `DONE_TIMEOUT`. It clears on every state entry. A timeout fires on the cycle the count equals the limit minus 1. The counter saturates and never wraps.
- Ideal bring-up, with lock and done already high: 1 (IDLE) + `RST_PULSE` + 3 (sync + detect) + `NUM_LANES`×(`RST_PULSE`+3) cycles from enable to `resetdone_o`.
- `resetdone_o` drops in the cycle after the state leaves UP.
- Reset mid-operation: the next edge is in IDLE with reset values.

## Structure
- **Package `qsfp_link_pkg`:** `state_t` enum, lane count default, and synchronizer depth constant (2).
- **Sub-module `sync_2ff`:** single-bit 2-flop synchronizer. It is instantiated for lock and for each lane, so `NUM_LANES`+1 instances.

## Test plan
1. **Basic bring-up.** `RST_PULSE`=4, lock and all dones tied high, `enable_i` rises → `qpll_reset_o` high 4 cycles; lanes 0..7 release in order, 7 cycles apart; `resetdone_o`=1 at cycle 1+4+3+8×7=64.
2. **Lock retries then FAIL.** `LOCK_TIMEOUT`=20, `MAX_RETRIES`=3, lock held low → 4 `qpll_reset_o` pulses, `retry_cnt_o` steps 1,2,3, then `fail_o`=1 with all resets high. `restart_i` → `fail_o`=0 and the sequence restarts.
3. **Late lane.** Lane 5 done arrives on its 3rd attempt → `retry_cnt_o` peaks at 2, clears on lane 5 success; lanes 6–7 proceed; `resetdone_o`=1.
4. **Lane drop in UP.** Lane 3 done drops → `lane_up_o`=0xF7, `resetdone_o`=0, only `gt_reset_o[3]` pulses; on recovery `lane_up_o`=0xFF, `resetdone_o`=1.
5. **Lock loss in UP, simultaneous with a lane-2 drop** → lock path wins; `lane_up_o`=0, `qpll_reset_o` pulses, full re-sequence.
6. **Reset mid-sequence.** `sys_rst_i` during LANE_WAIT of lane 4 → next cycle all resets high, `lane_up_o`=0; `enable_i` low holds IDLE.

Source files
------------

// File: rtl/qsfp_link_pkg.sv
// Shared types and constants for the QSFP link reset sequencer.
package qsfp_link_pkg;

  localparam int unsigned NUM_LANES_DEF = 8;
  localparam int unsigned SYNC_STAGES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_QPLL_RST  = 3'd1,
    ST_QPLL_WAIT = 3'd2,
    ST_LANE_RST  = 3'd3,
    ST_LANE_WAIT = 3'd4,
    ST_UP        = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

endpackage

// File: rtl/qsfp_link_reset_ctrl_sync.sv
// Single-bit multi-flop synchronizer for asynchronous transceiver status inputs.
module sync_2ff
  import qsfp_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/qsfp_link_reset_ctrl.sv
// Bring-up and recovery sequencer for the QSFP quad PLL and per-lane GT resets.
module qsfp_link_reset_ctrl
  import qsfp_link_pkg::*;
#(
  parameter int unsigned NUM_LANES    = NUM_LANES_DEF,
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned DONE_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic                                 sys_clk_i,
  input  logic                                 sys_rst_i,
  input  logic                                 enable_i,
  input  logic                                 restart_i,
  input  logic                                 qpll_lock_i,
  input  logic [NUM_LANES-1:0]                 lane_resetdone_i,
  output logic                                 qpll_reset_o,
  output logic [NUM_LANES-1:0]                 gt_reset_o,
  output logic [NUM_LANES-1:0]                 lane_up_o,
  output logic                                 resetdone_o,
  output logic                                 fail_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt_o
);

  localparam int unsigned MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int unsigned MAX_LIM = (MAX_AB > DONE_TIMEOUT) ? MAX_AB : DONE_TIMEOUT;
  localparam int unsigned CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;
  localparam int unsigned RET_W   = $clog2(MAX_RETRIES + 1);
  localparam int unsigned IDX_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLANK      = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [RET_W-1:0] RET_MAX    = RET_W'(MAX_RETRIES);

  function automatic logic [NUM_LANES-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_zero(input logic [NUM_LANES-1:0] v);
    lowest_zero = {IDX_W{1'b0}};
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      lowest_zero = v[i] ? lowest_zero : IDX_W'(i);
    end
  endfunction

  logic                 lock_s;
  logic [NUM_LANES-1:0] done_s;
  logic [NUM_LANES-1:0] drop_s;
  logic                 enter_s;
  state_t               state_r, state_n;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  logic [IDX_W-1:0]     lane_idx_r, lane_idx_n;
  logic [RET_W-1:0]     retry_r, retry_n;
  logic [NUM_LANES-1:0] lane_up_r, lane_up_n;
  logic                 fail_r, fail_n;
  logic                 qpll_reset_r, qpll_reset_n;
  logic [NUM_LANES-1:0] gt_reset_r, gt_reset_n;
  logic                 resetdone_r, resetdone_n;

  sync_2ff u_lock_sync (.clk(sys_clk_i), .rst(sys_rst_i), .d(qpll_lock_i), .q(lock_s));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_done_sync
    sync_2ff u_done_sync (.clk(sys_clk_i), .rst(sys_rst_i), .d(lane_resetdone_i[g]), .q(done_s[g]));
  end

  assign drop_s = lane_up_r & ~done_s;

  // sequencing decisions; wait states ignore status for SYNC_STAGES cycles so
  // a value captured before the reset was released is never mistaken for success
  always_comb begin
    state_n    = state_r;
    lane_idx_n = lane_idx_r;
    retry_n    = retry_r;
    lane_up_n  = lane_up_r;
    fail_n     = fail_r;
    enter_s    = 1'b0;
    if (!enable_i) begin
      state_n   = ST_IDLE;
      enter_s   = 1'b1;
      lane_up_n = {NUM_LANES{1'b0}};
      fail_n    = 1'b0;
      retry_n   = {RET_W{1'b0}};
    end else if (restart_i) begin
      state_n   = ST_QPLL_RST;
      enter_s   = 1'b1;
      lane_up_n = {NUM_LANES{1'b0}};
      fail_n    = 1'b0;
      retry_n   = {RET_W{1'b0}};
    end else if (!lock_s && (state_r == ST_LANE_RST || state_r == ST_LANE_WAIT || state_r == ST_UP)) begin
      state_n   = ST_QPLL_RST;
      enter_s   = 1'b1;
      lane_up_n = {NUM_LANES{1'b0}};
      retry_n   = {RET_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n = ST_QPLL_RST;
          enter_s = 1'b1;
        end
        ST_QPLL_RST: begin
          if (cnt_r == PULSE_LAST) begin
            state_n = ST_QPLL_WAIT;
            enter_s = 1'b1;
          end else begin
            state_n = ST_QPLL_RST;
          end
        end
        ST_QPLL_WAIT: begin
          if (lock_s && cnt_r >= BLANK) begin
            retry_n    = {RET_W{1'b0}};
            lane_idx_n = lowest_zero(lane_up_r);
            state_n    = ST_LANE_RST;
            enter_s    = 1'b1;
          end else if (cnt_r == LOCK_LAST) begin
            enter_s = 1'b1;
            if (retry_r < RET_MAX) begin
              retry_n = retry_r + RET_W'(1);
              state_n = ST_QPLL_RST;
            end else begin
              state_n   = ST_FAIL;
              fail_n    = 1'b1;
              lane_up_n = {NUM_LANES{1'b0}};
            end
          end else begin
            state_n = ST_QPLL_WAIT;
          end
        end
        ST_LANE_RST: begin
          if (cnt_r == PULSE_LAST) begin
            state_n = ST_LANE_WAIT;
            enter_s = 1'b1;
          end else begin
            state_n = ST_LANE_RST;
          end
        end
        ST_LANE_WAIT: begin
          if (done_s[lane_idx_r] && cnt_r >= BLANK) begin
            lane_up_n = lane_up_r | onehot(lane_idx_r);
            retry_n   = {RET_W{1'b0}};
            enter_s   = 1'b1;
            if (&lane_up_n) begin
              state_n = ST_UP;
            end else begin
              lane_idx_n = lowest_zero(lane_up_n);
              state_n    = ST_LANE_RST;
            end
          end else if (cnt_r == DONE_LAST) begin
            enter_s = 1'b1;
            if (retry_r < RET_MAX) begin
              retry_n = retry_r + RET_W'(1);
              state_n = ST_LANE_RST;
            end else begin
              state_n   = ST_FAIL;
              fail_n    = 1'b1;
              lane_up_n = {NUM_LANES{1'b0}};
            end
          end else begin
            state_n = ST_LANE_WAIT;
          end
        end
        ST_UP: begin
          if (|drop_s) begin
            lane_idx_n = lowest_zero(~drop_s);
            lane_up_n  = lane_up_r & ~onehot(lowest_zero(~drop_s));
            state_n    = ST_LANE_RST;
            enter_s    = 1'b1;
          end else begin
            state_n = ST_UP;
          end
        end
        ST_FAIL: begin
          state_n = ST_FAIL;
        end
        default: begin
          state_n = ST_IDLE;
          enter_s = 1'b1;
        end
      endcase
    end
  end

  // next values of the counter and of the registered outputs
  always_comb begin
    cnt_n        = enter_s ? {CNT_W{1'b0}} : ((cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1));
    qpll_reset_n = 1'b1;
    gt_reset_n   = {NUM_LANES{1'b1}};
    resetdone_n  = (state_n == ST_UP);
    case (state_n)
      ST_IDLE, ST_QPLL_RST, ST_FAIL: begin
        qpll_reset_n = 1'b1;
        gt_reset_n   = {NUM_LANES{1'b1}};
      end
      ST_QPLL_WAIT: begin
        qpll_reset_n = 1'b0;
        gt_reset_n   = {NUM_LANES{1'b1}};
      end
      ST_LANE_RST: begin
        qpll_reset_n = 1'b0;
        gt_reset_n   = ~lane_up_n;
      end
      ST_LANE_WAIT: begin
        qpll_reset_n = 1'b0;
        gt_reset_n   = ~lane_up_n & ~onehot(lane_idx_n);
      end
      ST_UP: begin
        qpll_reset_n = 1'b0;
        gt_reset_n   = {NUM_LANES{1'b0}};
      end
      default: begin
        qpll_reset_n = 1'b1;
        gt_reset_n   = {NUM_LANES{1'b1}};
      end
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      lane_idx_r   <= {IDX_W{1'b0}};
      retry_r      <= {RET_W{1'b0}};
      lane_up_r    <= {NUM_LANES{1'b0}};
      fail_r       <= 1'b0;
      qpll_reset_r <= 1'b1;
      gt_reset_r   <= {NUM_LANES{1'b1}};
      resetdone_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      lane_idx_r   <= lane_idx_n;
      retry_r      <= retry_n;
      lane_up_r    <= lane_up_n;
      fail_r       <= fail_n;
      qpll_reset_r <= qpll_reset_n;
      gt_reset_r   <= gt_reset_n;
      resetdone_r  <= resetdone_n;
    end
  end

  assign qpll_reset_o = qpll_reset_r;
  assign gt_reset_o   = gt_reset_r;
  assign lane_up_o    = lane_up_r;
  assign resetdone_o  = resetdone_r;
  assign fail_o       = fail_r;
  assign retry_cnt_o  = retry_r;

endmodule

// File: tb/tb_qsfp_link_reset_ctrl.sv
// Directed bench for qsfp_link_reset_ctrl: bring-up, retries, lane and lock recovery, reset.
module tb_qsfp_link_reset_ctrl;

  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst, enable, restart, lock;
  logic [NL-1:0] done;
  logic          qpll_reset, resetdone, fail;
  logic [NL-1:0] gt_reset, lane_up;
  logic [1:0]    retry_cnt;

  int checks = 0;
  int errors = 0;

  qsfp_link_reset_ctrl #(
    .NUM_LANES(NL), .RST_PULSE(4), .LOCK_TIMEOUT(20), .DONE_TIMEOUT(20), .MAX_RETRIES(3)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .enable_i(enable), .restart_i(restart),
    .qpll_lock_i(lock), .lane_resetdone_i(done),
    .qpll_reset_o(qpll_reset), .gt_reset_o(gt_reset), .lane_up_o(lane_up),
    .resetdone_o(resetdone), .fail_o(fail), .retry_cnt_o(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, qfall, rd_at, pulse, bad, maxr, r_at5, qf, nchg, seq;
    int gfall [NL];
    logic prev_q, seen5;
    logic [1:0] prev_r;

    rst = 1'b1; enable = 1'b0; restart = 1'b0; lock = 1'b1; done = 8'hFF;
    repeat (3) step();
    check("rst_qpll", qpll_reset, 1);
    check("rst_gt", gt_reset, 8'hFF);
    check("rst_lane_up", lane_up, 0);
    check("rst_resetdone", resetdone, 0);
    check("rst_fail", fail, 0);
    check("rst_retry", retry_cnt, 0);
    rst = 1'b0;
    repeat (2) step();
    check("idle_qpll", qpll_reset, 1);

    // basic bring-up with lock and dones high
    enable = 1'b1;
    qfall = 0; rd_at = 0;
    for (int i = 0; i < NL; i++) gfall[i] = 0;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (qfall == 0 && !qpll_reset) qfall = c;
      for (int i = 0; i < NL; i++) if (gfall[i] == 0 && !gt_reset[i]) gfall[i] = c;
      if (rd_at == 0 && resetdone) rd_at = c;
    end
    check("bringup_qpll_fall", qfall, 5);
    for (int i = 0; i < NL; i++) check($sformatf("bringup_lane%0d_release", i), gfall[i], 12 + 7 * i);
    check("bringup_resetdone_cycle", rd_at, 64);
    check("bringup_lane_up", lane_up, 8'hFF);

    // lane 3 drop in UP
    done[3] = 1'b0;
    n = 0;
    while (resetdone && n < 20) begin step(); n++; end
    check("drop_latency", n, 3);
    check("drop_lane_up", lane_up, 8'hF7);
    check("drop_gt", gt_reset, 8'h08);
    check("drop_qpll", qpll_reset, 0);
    done[3] = 1'b1;
    pulse = 1; bad = 0; n = 0;
    while (!resetdone && n < 30) begin
      step(); n++;
      if (gt_reset == 8'h08) pulse++;
      if ((gt_reset & 8'hF7) != 8'h00) bad++;
    end
    check("drop_pulse_len", pulse, 4);
    check("drop_other_gt", bad, 0);
    check("drop_recover_lane_up", lane_up, 8'hFF);
    check("drop_recover_resetdone", resetdone, 1);

    // lock loss together with lane 2 drop
    lock = 1'b0; done[2] = 1'b0;
    n = 0;
    while (resetdone && n < 20) begin step(); n++; end
    check("lockloss_latency", n, 3);
    check("lockloss_lane_up", lane_up, 8'h00);
    check("lockloss_qpll", qpll_reset, 1);
    check("lockloss_gt", gt_reset, 8'hFF);
    lock = 1'b1; done[2] = 1'b1;
    n = 0;
    while (!resetdone && n < 100) begin step(); n++; end
    check("lockloss_resequence_cycles", n, 63);
    check("lockloss_lane_up_final", lane_up, 8'hFF);

    // late lane 5: done arrives on the third attempt
    done[5] = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
    check("late_restart_qpll", qpll_reset, 1);
    check("late_restart_lane_up", lane_up, 0);
    maxr = 0; n = 0;
    while (retry_cnt != 2'd2 && n < 400) begin
      step(); n++;
      if (retry_cnt > maxr) maxr = retry_cnt;
    end
    check("late_retry_reached", retry_cnt, 2);
    done[5] = 1'b1;
    seen5 = 1'b0; r_at5 = -1; n = 0;
    while (!resetdone && n < 200) begin
      step(); n++;
      if (retry_cnt > maxr) maxr = retry_cnt;
      if (!seen5 && lane_up[5]) begin seen5 = 1'b1; r_at5 = retry_cnt; end
    end
    check("late_retry_peak", maxr, 2);
    check("late_retry_cleared", r_at5, 0);
    check("late_lane_up", lane_up, 8'hFF);
    check("late_fail", fail, 0);

    // lock never arrives: retries then FAIL
    lock = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
    prev_q = qpll_reset; prev_r = retry_cnt;
    qf = 0; nchg = 0; seq = 0; n = 0;
    while (!fail && n < 600) begin
      step(); n++;
      if (prev_q && !qpll_reset) qf++;
      if (retry_cnt != prev_r) begin nchg++; seq = seq * 16 + retry_cnt; end
      prev_q = qpll_reset; prev_r = retry_cnt;
    end
    check("fail_qpll_pulses", qf, 4);
    check("fail_retry_sequence", seq, 32'h123);
    check("fail_retry_changes", nchg, 3);
    check("fail_flag", fail, 1);
    check("fail_qpll", qpll_reset, 1);
    check("fail_gt", gt_reset, 8'hFF);
    check("fail_lane_up", lane_up, 0);
    repeat (10) step();
    check("fail_sticky", fail, 1);
    lock = 1'b1;
    restart = 1'b1; step(); restart = 1'b0;
    check("restart_clears_fail", fail, 0);
    check("restart_clears_retry", retry_cnt, 0);
    n = 0;
    while (!resetdone && n < 100) begin step(); n++; end
    check("restart_resetdone", resetdone, 1);

    // sys_rst during lane 4 wait, then enable low holds IDLE
    done[4] = 1'b0;
    restart = 1'b1; step(); restart = 1'b0;
    n = 0;
    while (gt_reset != 8'hE0 && n < 100) begin step(); n++; end
    check("midrst_lane4_wait_gt", gt_reset, 8'hE0);
    check("midrst_lane_up", lane_up, 8'h0F);
    step();
    rst = 1'b1; enable = 1'b0;
    step();
    rst = 1'b0;
    check("midrst_qpll", qpll_reset, 1);
    check("midrst_gt", gt_reset, 8'hFF);
    check("midrst_lane_up_clr", lane_up, 0);
    check("midrst_resetdone", resetdone, 0);
    check("midrst_fail", fail, 0);
    done[4] = 1'b1;
    repeat (5) step();
    check("disabled_qpll", qpll_reset, 1);
    check("disabled_lane_up", lane_up, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
